frame_flush_sequencer: RTL and testbench
========================================

FRAME_FLUSH_SEQUENCER -- requirements
Module: frame_flush_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 26'd0, SDRAM byte address of pixel 0.
REQ-002 SHALL have parameter IMG_PIXELS, default 102400, rendered pixels held in the on-chip frame buffer.
REQ-003 SHALL have parameter FRAME_PIXELS, default 307200, total 640x480 words per SDRAM frame; FRAME_PIXELS >= IMG_PIXELS >= 1.
REQ-004 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 frame_ready  in  1  start pulse from the blender; frame buffer complete.
REQ-007 buf_raddr  out  17  frame buffer read address.
REQ-008 buf_rdata  in  24  frame buffer read data {R[23:16],G[15:8],B[7:0]}, valid one cycle after buf_raddr.
REQ-009 SD_write  out  1  Avalon-MM write request.
REQ-010 SD_address  out  26  Avalon-MM byte address.
REQ-011 SD_wdata  out  32  Avalon-MM write data.
REQ-012 waitrequest  in  1  slave stall; a write is accepted on a cycle with SD_write=1 and waitrequest=0.
REQ-013 busy  out  1  high from the cycle after a start through the cycle finished is high.
REQ-014 finished  out  1  single-cycle pulse when the last word is accepted.

Function
REQ-015 SHALL implement states IDLE, FETCH, WRITE, PAD, DONE.
REQ-016 IDLE: on frame_ready=1, clear 19-bit word counter wc to 0, drive buf_raddr=0, go to FETCH.
REQ-017 FETCH: one cycle for RAM latency; at its end, register SD_wdata={8'h00,B,G,R} from buf_rdata, SD_address=BASE_ADDR+4*wc, SD_write=1, go to WRITE.
REQ-018 WRITE: SD_write, SD_address and SD_wdata SHALL stay constant while waitrequest=1.
REQ-019 WRITE on acceptance: wc increments; if new wc<IMG_PIXELS drive buf_raddr=wc[16:0], deassert SD_write, go to FETCH (2 cycles/pixel minimum); else go to PAD if enabled (REQ-027) or DONE.
REQ-020 PAD: SD_write=1, SD_wdata=32'h0, SD_address=BASE_ADDR+4*wc, held while waitrequest=1; on acceptance wc increments, SD_address advances by 4 the next cycle (back-to-back, 1 word/cycle); after the word with wc=FRAME_PIXELS-1 is accepted, deassert SD_write, go to DONE.
REQ-021 DONE: finished=1 for exactly one cycle, then IDLE; busy=0 in IDLE.
REQ-022 frame_ready SHALL be ignored in every state except IDLE; frame_ready held high in IDLE restarts a new flush the cycle after DONE.
REQ-023 Address arithmetic SHALL be 26-bit modulo 2^26; wc SHALL never exceed FRAME_PIXELS.
REQ-024 SD_write SHALL never be deasserted in WRITE or PAD before acceptance.
REQ-025 Exactly IMG_PIXELS image words (plus padding when enabled) SHALL be written per start, each address written once, in ascending order.

Reset
REQ-026 On reset=0, immediately: state=IDLE, wc=0, buf_raddr=0, SD_write=0, SD_address=BASE_ADDR, SD_wdata=0, busy=0, finished=0; a flush in progress is abandoned and does not resume.

Configuration
REQ-027 Macro FLUSH_PAD_EN: defined -> PAD state present, words IMG_PIXELS..FRAME_PIXELS-1 written as black; undefined -> PAD omitted, WRITE goes to DONE after image word IMG_PIXELS-1, FRAME_PIXELS unused.

Verification (IMG_PIXELS=4, FRAME_PIXELS=8, BASE_ADDR=26'h100, RAM preloaded pixel n = {8'h10+n,8'h20+n,8'h30+n})
REQ-028 waitrequest=0, FLUSH_PAD_EN defined, pulse frame_ready -> writes 0x100..0x11C: 0x00302010,0x00312111,0x00322212,0x00332313, then four 0x00000000; finished one pulse; 8 total accepts.
REQ-029 Same, FLUSH_PAD_EN undefined -> only 0x100..0x10C written, finished after 4th accept, SD_write never asserted again.
REQ-030 waitrequest=1 for 5 cycles on word 2 -> SD_address=0x108, SD_wdata=0x00322212 stable all 5 cycles, exactly one accept recorded.
REQ-031 frame_ready pulsed during WRITE of word 1 -> ignored; single flush of 8 words, one finished pulse.
REQ-032 reset=0 asserted during PAD word 5 with waitrequest=1 -> SD_write=0, busy=0 immediately; next frame_ready restarts at 0x100.

Source files
------------

// File: rtl/frame_flush_sequencer.sv
// Copies the on-chip frame buffer to SDRAM over Avalon-MM, one word per pixel.
// Define FLUSH_PAD_EN to pad the rest of the SDRAM frame with black words.
module frame_flush_sequencer #(
  parameter logic [25:0] BASE_ADDR    = 26'd0,
  parameter int          IMG_PIXELS   = 102400,
  parameter int          FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_ready,
  output logic [16:0] buf_raddr,
  input  logic [23:0] buf_rdata,
  output logic        SD_write,
  output logic [25:0] SD_address,
  output logic [31:0] SD_wdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        finished
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
`ifdef FLUSH_PAD_EN
    PAD,
`endif
    DONE
  } state_t;

  localparam logic [18:0] IMG_END   = 19'(IMG_PIXELS);
  localparam logic [18:0] FRAME_END = 19'(FRAME_PIXELS);

  state_t      state, state_next;
  logic [18:0] wc, wc_next, wc_inc;
  logic        write_next;
  logic [25:0] addr_next;
  logic [31:0] wdata_next;
  logic        accept;

  function automatic logic [25:0] word_addr(input logic [18:0] n);
    return BASE_ADDR + {5'd0, n, 2'b00};
  endfunction

  assign accept   = SD_write && !waitrequest;
  assign wc_inc   = wc + 19'd1;
  assign busy     = (state != IDLE);
  assign finished = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wc         <= '0;
      SD_write   <= 1'b0;
      SD_address <= BASE_ADDR;
      SD_wdata   <= '0;
    end else begin
      state      <= state_next;
      wc         <= wc_next;
      SD_write   <= write_next;
      SD_address <= addr_next;
      SD_wdata   <= wdata_next;
    end
  end

  // buf_raddr is presented combinationally so the RAM registers it on the edge
  // entering FETCH and its data is ready by the end of FETCH.
  always_comb begin
    state_next = state;
    wc_next    = wc;
    write_next = SD_write;
    addr_next  = SD_address;
    wdata_next = SD_wdata;
    buf_raddr  = wc[16:0];
    case (state)
      IDLE: begin
        buf_raddr = '0;
        if (frame_ready) begin
          wc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        wdata_next = {8'h00, buf_rdata[7:0], buf_rdata[15:8], buf_rdata[23:16]};
        addr_next  = word_addr(wc);
        write_next = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        if (accept) begin
          wc_next = wc_inc;
          if (wc_inc < IMG_END && wc_inc < FRAME_END) begin
            buf_raddr  = wc_inc[16:0];
            write_next = 1'b0;
            state_next = FETCH;
`ifdef FLUSH_PAD_EN
          end else if (wc_inc < FRAME_END) begin
            wdata_next = '0;
            addr_next  = word_addr(wc_inc);
            state_next = PAD;
`endif
          end else begin
            write_next = 1'b0;
            state_next = DONE;
          end
        end
      end
`ifdef FLUSH_PAD_EN
      // Padding keeps SD_write high and streams one black word per accept.
      PAD: begin
        if (accept) begin
          wc_next = wc_inc;
          if (wc_inc < FRAME_END) begin
            addr_next = word_addr(wc_inc);
          end else begin
            write_next = 1'b0;
            state_next = DONE;
          end
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_flush_sequencer.sv
// Directed self-checking bench for frame_flush_sequencer (IMG=4, FRAME=8, base 0x100).
// Works with FLUSH_PAD_EN defined or undefined.
module tb_frame_flush_sequencer;

`ifdef FLUSH_PAD_EN
  localparam int          EXP_WORDS   = 8;
  localparam logic [25:0] RST_ADDR    = 26'h114;
  localparam int          RST_ACCEPTS = 5;
`else
  localparam int          EXP_WORDS   = 4;
  localparam logic [25:0] RST_ADDR    = 26'h108;
  localparam int          RST_ACCEPTS = 2;
`endif

  logic        clk;
  logic        reset;
  logic        frame_ready;
  logic [16:0] buf_raddr;
  logic [23:0] buf_rdata;
  logic        SD_write;
  logic [25:0] SD_address;
  logic [31:0] SD_wdata;
  logic        waitrequest;
  logic        busy;
  logic        finished;

  int          checks;
  int          failures;
  int          fin_count;
  logic [25:0] acc_addr[$];
  logic [31:0] acc_data[$];

  frame_flush_sequencer #(
    .BASE_ADDR   (26'h100),
    .IMG_PIXELS  (4),
    .FRAME_PIXELS(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_ready(frame_ready),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .SD_write   (SD_write),
    .SD_address (SD_address),
    .SD_wdata   (SD_wdata),
    .waitrequest(waitrequest),
    .busy       (busy),
    .finished   (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffer preloaded with pixel n = {10+n, 20+n, 30+n}
  always @(posedge clk)
    buf_rdata <= {8'h10 + buf_raddr[7:0], 8'h20 + buf_raddr[7:0], 8'h30 + buf_raddr[7:0]};

  always @(posedge clk) begin
    if (reset && SD_write && !waitrequest) begin
      acc_addr.push_back(SD_address);
      acc_data.push_back(SD_wdata);
    end
    if (reset && finished) fin_count++;
  end

  function automatic logic [25:0] exp_addr(input int n);
    return 26'h100 + 26'(4 * n);
  endfunction

  function automatic logic [31:0] exp_data(input int n);
    logic [7:0] k;
    k = 8'(n);
    if (n < 4) return {8'h00, 8'h30 + k, 8'h20 + k, 8'h10 + k};
    return 32'h0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic clear_log();
    acc_addr.delete();
    acc_data.delete();
  endtask

  task automatic wait_for_write(input string tag, input logic [25:0] addr);
    int cyc;
    cyc = 0;
    while (!(SD_write && SD_address == addr) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) checkOutput({tag, "_wait_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_finished(input string tag);
    int start;
    int cyc;
    start = fin_count;
    cyc = 0;
    while (fin_count == start && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    checkOutput({tag, "_finished_pulses"}, 32'(fin_count - start), 32'd1);
    checkOutput({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_write_idle"}, {31'd0, SD_write}, 32'd0);
  endtask

  task automatic check_log(input string tag, input int n_exp);
    checkOutput({tag, "_count"}, 32'(acc_addr.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < acc_addr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), {6'd0, acc_addr[i]}, {6'd0, exp_addr(i)});
      checkOutput($sformatf("%s_data%0d", tag, i), acc_data[i], exp_data(i));
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    fin_count   = 0;
    reset       = 1'b0;
    frame_ready = 1'b0;
    waitrequest = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_write", {31'd0, SD_write}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_finished", {31'd0, finished}, 32'd0);
    checkOutput("rst_address", {6'd0, SD_address}, 32'h100);
    checkOutput("rst_wdata", SD_wdata, 32'h0);
    checkOutput("rst_raddr", {15'd0, buf_raddr}, 32'd0);
    reset = 1'b1;

    // Plain flush with no stalls
    clear_log();
    applyStimulus();
    checkOutput("plain_busy_start", {31'd0, busy}, 32'd1);
    wait_finished("plain");
    check_log("plain", EXP_WORDS);

    // Five stall cycles on word 2
    clear_log();
    applyStimulus();
    wait_for_write("stall", 26'h108);
    waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_write%0d", i), {31'd0, SD_write}, 32'd1);
      checkOutput($sformatf("stall_addr%0d", i), {6'd0, SD_address}, 32'h108);
      checkOutput($sformatf("stall_data%0d", i), SD_wdata, 32'h00322212);
    end
    waitrequest = 1'b0;
    wait_finished("stall");
    check_log("stall", EXP_WORDS);

    // frame_ready while word 1 is being written must be ignored
    clear_log();
    applyStimulus();
    wait_for_write("ignore", 26'h104);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    wait_finished("ignore");
    check_log("ignore", EXP_WORDS);

    // Reset mid-flush while stalled, then a fresh flush from the start
    clear_log();
    applyStimulus();
    wait_for_write("abort", RST_ADDR);
    waitrequest = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_write", {31'd0, SD_write}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_address", {6'd0, SD_address}, 32'h100);
    @(negedge clk);
    waitrequest = 1'b0;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("abort_accepts", 32'(acc_addr.size()), 32'(RST_ACCEPTS));
    checkOutput("abort_no_resume", {31'd0, SD_write}, 32'd0);
    checkOutput("abort_idle", {31'd0, busy}, 32'd0);
    clear_log();
    applyStimulus();
    wait_finished("restart");
    check_log("restart", EXP_WORDS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
